// File: rtl/alu_operand_sequencer.sv
// Byte-serial front end for the 16-bit ALU: gathers A/B little-endian plus op select,
// holds them for EXEC_CYCLES, then returns the 16-bit result as two bytes.
module alu_operand_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  output logic [3:0]  alu_sel,
  output logic [15:0] data_a,
  output logic [15:0] data_b,
  input  logic [15:0] y,
  input  logic [2:0]  flags,
  output logic [7:0]  out_data,
  output logic [2:0]  out_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {A_LO, A_HI, B_LO, B_HI, EXEC, SEND_LO, SEND_HI} state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit         TO_EN     = (TIMEOUT > 0);

  state_t      state, state_nxt;
  logic [15:0] result;
  logic [3:0]  exec_cnt;
  logic [7:0]  to_cnt;
  logic        xfer, in_frame, to_fire;

  assign in_ready  = (state == A_LO) || (state == A_HI) || (state == B_LO) || (state == B_HI);
  assign xfer      = in_valid && in_ready;
  assign in_frame  = (state == A_HI) || (state == B_LO) || (state == B_HI);
  // Abort when this idle cycle would bring the counter to TIMEOUT; a transfer wins.
  assign to_fire   = TO_EN && in_frame && !xfer && (to_cnt == TO_LAST);
  assign busy      = (state != A_LO);
  assign out_valid = (state == SEND_LO) || (state == SEND_HI);
  assign out_data  = (state == SEND_HI) ? result[15:8] : result[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= A_LO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      A_LO:    if (xfer) state_nxt = A_HI;
      A_HI:    if (xfer) state_nxt = B_LO; else if (to_fire) state_nxt = A_LO;
      B_LO:    if (xfer) state_nxt = B_HI; else if (to_fire) state_nxt = A_LO;
      B_HI:    if (xfer) state_nxt = EXEC; else if (to_fire) state_nxt = A_LO;
      EXEC:    if (exec_cnt == 4'd0) state_nxt = SEND_LO;
      SEND_LO: if (out_ready) state_nxt = SEND_HI;
      SEND_HI: if (out_ready) state_nxt = A_LO;
      default: state_nxt = A_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_sel     <= '0;
      data_a      <= '0;
      data_b      <= '0;
      result      <= '0;
      out_flags   <= '0;
      exec_cnt    <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_fire;

      if (xfer) begin
        case (state)
          A_LO: begin
            data_a[7:0] <= in_data;
            alu_sel     <= op_sel;
          end
          A_HI:    data_a[15:8] <= in_data;
          B_LO:    data_b[7:0]  <= in_data;
          B_HI:    data_b[15:8] <= in_data;
          default: ;
        endcase
      end

      if (state == B_HI && xfer)
        exec_cnt <= EXEC_LOAD;
      else if (state == EXEC && exec_cnt != 4'd0)
        exec_cnt <= exec_cnt - 4'd1;

      if (state == EXEC && exec_cnt == 4'd0) begin
        result    <= y;
        out_flags <= flags;
      end

      // Idle counter only meaningful mid-frame; clearing outside covers state entry.
      if (!in_frame || xfer || to_fire)
        to_cnt <= '0;
      else if (to_cnt != 8'hFF)
        to_cnt <= to_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: u0 (EXEC_CYCLES=1, TIMEOUT=8) carries most steps, u1 (EXEC_CYCLES=4)
// checks the longer execute latency. The ALU is modelled as y=a+b, flags={y==0,0,0}.
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [3:0]  op_sel;
  logic        out_ready;

  logic        in_ready0, ov0, busy0, te0;
  logic [3:0]  alu_sel0;
  logic [15:0] a0, b0, y0;
  logic [2:0]  f0, of0;
  logic [7:0]  od0;

  logic        in_ready1, ov1, busy1, te1;
  logic [3:0]  alu_sel1;
  logic [15:0] a1, b1, y1;
  logic [2:0]  f1, of1;
  logic [7:0]  od1;

  int npass = 0;
  int ntotal = 0;
  int consumed = 0;

  localparam logic [15:0] SUM1 = 16'h1234 + 16'h5678;
  localparam logic [15:0] SUM2 = 16'h00FF + 16'h0101;
  localparam logic [15:0] SUM3 = 16'h0002 + 16'h0003;

  always #5 clk = ~clk;

  assign y0 = a0 + b0;
  assign f0 = {y0 == 16'd0, 2'b00};
  assign y1 = a1 + b1;
  assign f1 = {y1 == 16'd0, 2'b00};

  alu_operand_sequencer #(.EXEC_CYCLES(1), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .op_sel(op_sel), .alu_sel(alu_sel0), .data_a(a0), .data_b(b0), .y(y0), .flags(f0),
    .out_data(od0), .out_flags(of0), .out_valid(ov0), .out_ready(out_ready),
    .busy(busy0), .timeout_err(te0));

  alu_operand_sequencer #(.EXEC_CYCLES(4), .TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .op_sel(op_sel), .alu_sel(alu_sel1), .data_a(a1), .data_b(b1), .y(y1), .flags(f1),
    .out_data(od1), .out_flags(of1), .out_valid(ov1), .out_ready(out_ready),
    .busy(busy1), .timeout_err(te1));

  // Inputs only change just after posedge, so the negedge view predicts the next edge's handshake.
  always @(negedge clk) if (in_valid && in_ready0) consumed++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] op, input bit keep);
    bit ok;
    ok = 1'b0;
    in_data = d; op_sel = op; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready0) begin step(); ok = 1'b1; break; end
      step();
    end
    if (!keep) in_valid = 1'b0;
    chk("push_handshake", 32'(ok), 32'd1);
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    push(a[7:0], op, 1'b0);
    push(a[15:8], op, 1'b0);
    push(b[7:0], op, 1'b0);
    push(b[15:8], op, 1'b0);
  endtask

  initial begin
    bit stable;
    int lat;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; op_sel = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_data_a", 32'(a0), 32'd0);
    chk("rst_data_b", 32'(b0), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel0), 32'd0);
    chk("rst_timeout_err", 32'(te0), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Basic frame, no back-pressure
    frame(16'h1234, 16'h5678, 4'h3);
    chk("f1_alu_sel", 32'(alu_sel0), 32'h3);
    chk("f1_data_a", 32'(a0), 32'h1234);
    chk("f1_data_b", 32'(b0), 32'h5678);
    chk("f1_exec_in_ready", 32'(in_ready0), 32'd0);
    chk("f1_exec_ov", 32'(ov0), 32'd0);
    step();
    chk("f1_lo_valid", 32'(ov0), 32'd1);
    chk("f1_lo_data", 32'(od0), 32'(SUM1[7:0]));
    chk("f1_lo_flags", 32'(of0), 32'd0);
    step();
    chk("f1_hi_valid", 32'(ov0), 32'd1);
    chk("f1_hi_data", 32'(od0), 32'(SUM1[15:8]));
    chk("f1_hi_flags", 32'(of0), 32'd0);
    step();
    chk("f1_done_ov", 32'(ov0), 32'd0);
    chk("f1_done_busy", 32'(busy0), 32'd0);

    // Back-pressure for 10 cycles on the low byte
    out_ready = 1'b0;
    frame(16'h1234, 16'h5678, 4'h3);
    step();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(ov0 === 1'b1 && od0 === SUM1[7:0] && in_ready0 === 1'b0)) stable = 1'b0;
      step();
    end
    chk("bp_stable_10", 32'(stable), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_hi_valid", 32'(ov0), 32'd1);
    chk("bp_hi_data", 32'(od0), 32'(SUM1[15:8]));
    step();
    chk("bp_done_ov", 32'(ov0), 32'd0);

    // EXEC_CYCLES=4 latency on u1, zero operands
    rst = 1'b1; step(); rst = 1'b0; step();
    frame(16'h0000, 16'h0000, 4'h1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (ov1) begin lat = k; break; end
    end
    chk("x4_latency", 32'(lat), 32'd4);
    chk("x4_lo_data", 32'(od1), 32'h00);
    chk("x4_zero_flag", 32'(of1[2]), 32'd1);
    step();
    chk("x4_hi_data", 32'(od1), 32'h00);
    step();

    // Timeout after two bytes
    rst = 1'b1; step(); rst = 1'b0; step();
    push(8'h11, 4'h5, 1'b0);
    push(8'h22, 4'h5, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (te0 !== 1'b0 || busy0 !== 1'b1) stable = 1'b0;
    end
    chk("to_quiet_7", 32'(stable), 32'd1);
    step();
    chk("to_pulse", 32'(te0), 32'd1);
    chk("to_busy", 32'(busy0), 32'd0);
    chk("to_in_ready", 32'(in_ready0), 32'd1);
    step();
    chk("to_pulse_end", 32'(te0), 32'd0);
    frame(16'h00FF, 16'h0101, 4'h6);
    chk("to_next_a", 32'(a0), 32'h00FF);
    chk("to_next_b", 32'(b0), 32'h0101);
    step();
    chk("to_next_lo", 32'(od0), 32'(SUM2[7:0]));
    step();
    chk("to_next_hi", 32'(od0), 32'(SUM2[15:8]));
    step();

    // Asynchronous reset while in SEND_HI
    out_ready = 1'b0;
    frame(16'hABCD, 16'h1111, 4'h2);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ar_in_send_hi", 32'(ov0), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_ov", 32'(ov0), 32'd0);
    chk("ar_busy", 32'(busy0), 32'd0);
    chk("ar_data_a", 32'(a0), 32'd0);
    chk("ar_data_b", 32'(b0), 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ov0 !== 1'b0) stable = 1'b0;
    end
    chk("ar_no_second_byte", 32'(stable), 32'd1);

    // in_valid held high across two frames
    consumed = 0;
    push(8'h02, 4'h7, 1'b1);
    push(8'h00, 4'h7, 1'b1);
    push(8'h03, 4'h7, 1'b1);
    push(8'h00, 4'h7, 1'b1);
    in_data = 8'h10; op_sel = 4'h9;
    chk("hv_f1_alu_sel", 32'(alu_sel0), 32'h7);
    chk("hv_exec_ready", 32'(in_ready0), 32'd0);
    step();
    chk("hv_lo_ready", 32'(in_ready0), 32'd0);
    chk("hv_lo_data", 32'(od0), 32'(SUM3[7:0]));
    step();
    chk("hv_hi_ready", 32'(in_ready0), 32'd0);
    chk("hv_count_f1", 32'(consumed), 32'd4);
    step();
    push(8'h10, 4'h9, 1'b1);
    push(8'h00, 4'h2, 1'b1);
    push(8'h20, 4'h2, 1'b1);
    push(8'h00, 4'h2, 1'b0);
    chk("hv_f2_alu_sel", 32'(alu_sel0), 32'h9);
    chk("hv_f2_a", 32'(a0), 32'h0010);
    chk("hv_f2_b", 32'(b0), 32'h0020);
    step(); step(); step();
    chk("hv_count_total", 32'(consumed), 32'd8);
    chk("hv_idle", 32'(busy0), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
